// File: rtl/axi4_lite_reg_slave.sv
// axi4_lite_reg_slave: AXI4-Lite slave over a bank of 32-bit registers with byte strobes.
module axi4_lite_reg_slave #(
  parameter int          NUM_REGS  = 8,
  parameter logic [31:0] RESET_VAL = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              AWADDR,
  input  logic                     AWVALID,
  output logic                     AWREADY,
  input  logic [31:0]              WDATA,
  input  logic [3:0]               WSTRB,
  input  logic                     WVALID,
  output logic                     WREADY,
  output logic [1:0]               BRESP,
  output logic                     BVALID,
  input  logic                     BREADY,
  input  logic [31:0]              ARADDR,
  input  logic                     ARVALID,
  output logic                     ARREADY,
  output logic [31:0]              RDATA,
  output logic [1:0]               RRESP,
  output logic                     RVALID,
  input  logic                     RREADY,
  output logic [NUM_REGS*32-1:0]   regs_o
);
  localparam int IW = $clog2(NUM_REGS);
  logic [31:0] regs [NUM_REGS];
  logic        aw_held, w_held;
  logic [31:2] awaddr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        aw_hs, w_hs, ar_hs, commit, wr_ok, rd_ok;
  logic [31:2] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        unused_addr_bits;
  assign AWREADY = !aw_held && !BVALID;
  assign WREADY  = !w_held && !BVALID;
  assign ARREADY = !RVALID;
  assign aw_hs   = AWVALID && AWREADY;
  assign w_hs    = WVALID && WREADY;
  assign ar_hs   = ARVALID && ARREADY;
  // The channel completing this cycle supplies its live value; the other comes from its capture.
  assign wr_addr = aw_held ? awaddr_q : AWADDR[31:2];
  assign wr_data = w_held ? wdata_q : WDATA;
  assign wr_strb = w_held ? wstrb_q : WSTRB;
  assign commit  = (aw_held || aw_hs) && (w_held || w_hs);
  assign wr_ok   = wr_addr < 30'(NUM_REGS);
  assign rd_ok   = ARADDR[31:2] < 30'(NUM_REGS);
  assign unused_addr_bits = ^{AWADDR[1:0], ARADDR[1:0]};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      BVALID   <= 1'b0;
      BRESP    <= 2'b00;
      RVALID   <= 1'b0;
      RDATA    <= '0;
      RRESP    <= 2'b00;
    end else begin
      if (aw_hs) awaddr_q <= AWADDR[31:2];
      if (w_hs) begin
        wdata_q <= WDATA;
        wstrb_q <= WSTRB;
      end
      aw_held <= !commit && (aw_held || aw_hs);
      w_held  <= !commit && (w_held || w_hs);
      if (commit && wr_ok)
        for (int b = 0; b < 4; b++)
          if (wr_strb[b]) regs[wr_addr[IW+1:2]][8*b +: 8] <= wr_data[8*b +: 8];
      if (commit) begin
        BVALID <= 1'b1;
        BRESP  <= wr_ok ? 2'b00 : 2'b10;
      end else if (BREADY) BVALID <= 1'b0;
      // Nonblocking read of regs returns the value before any same-edge write.
      if (ar_hs) begin
        RVALID <= 1'b1;
        RDATA  <= rd_ok ? regs[ARADDR[IW+1:2]] : 32'h0;
        RRESP  <= rd_ok ? 2'b00 : 2'b10;
      end else if (RREADY) RVALID <= 1'b0;
    end
  end
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
    assign regs_o[32*i +: 32] = regs[i];
  end
endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// tb_axi4_lite_reg_slave: directed and random AXI4-Lite traffic checked against an array model.
module tb_axi4_lite_reg_slave;
  localparam int          N  = 8;
  localparam logic [31:0] RV = 32'hA5A5_0000;
  logic clk = 0, rst = 1;
  logic [31:0] AWADDR = 0, WDATA = 0, ARADDR = 0, RDATA;
  logic [3:0]  WSTRB = 0;
  logic AWVALID = 0, WVALID = 0, BREADY = 0, ARVALID = 0, RREADY = 0;
  logic AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [1:0] BRESP, RRESP;
  logic [N*32-1:0] regs_o;
  logic [31:0] m [N];
  int n_checks = 0, n_fail = 0;

  axi4_lite_reg_slave #(.NUM_REGS(N), .RESET_VAL(RV)) dut (
    .clk(clk), .rst(rst),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .regs_o(regs_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < N; i++) chk($sformatf("%s_reg%0d", tag, i), regs_o[32*i +: 32], m[i]);
  endtask

  function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    if (addr / 4 >= N) return 2'b10;
    for (int b = 0; b < 4; b++)
      if (strb[b]) m[addr / 4][8*b +: 8] = data[8*b +: 8];
    return 2'b00;
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int gap, input bit aw_first);
    logic [1:0] resp;
    if (gap == 0) begin
      chk("aw_ready_idle", 32'(AWREADY), 1);
      chk("w_ready_idle", 32'(WREADY), 1);
      AWADDR = addr; AWVALID = 1; WDATA = data; WSTRB = strb; WVALID = 1;
      tick;
      AWVALID = 0; WVALID = 0;
    end else begin
      if (aw_first) begin AWADDR = addr; AWVALID = 1; end
      else begin WDATA = data; WSTRB = strb; WVALID = 1; end
      tick;
      AWVALID = 0; WVALID = 0;
      for (int k = 0; k < gap; k++) begin
        chk("wait_bvalid", 32'(BVALID), 0);
        chk("wait_aw_ready", 32'(AWREADY), aw_first ? 0 : 1);
        chk("wait_w_ready", 32'(WREADY), aw_first ? 1 : 0);
        if (k < gap - 1) tick;
      end
      if (aw_first) begin WDATA = data; WSTRB = strb; WVALID = 1; end
      else begin AWADDR = addr; AWVALID = 1; end
      tick;
      AWVALID = 0; WVALID = 0;
    end
    resp = model_write(addr, data, strb);
    chk("bvalid", 32'(BVALID), 1);
    chk("bresp", 32'(BRESP), 32'(resp));
    chk("aw_ready_busy", 32'(AWREADY), 0);
    BREADY = 1;
    tick;
    BREADY = 0;
    chk("bvalid_clear", 32'(BVALID), 0);
    if (addr / 4 < N) chk("reg_after_write", regs_o[32*(addr/4) +: 32], m[addr / 4]);
  endtask

  task automatic axi_read(input logic [31:0] addr);
    logic [31:0] exp;
    exp = (addr / 4 < N) ? m[addr / 4] : 32'h0;
    chk("ar_ready_idle", 32'(ARREADY), 1);
    ARADDR = addr; ARVALID = 1;
    tick;
    ARVALID = 0;
    chk("rvalid", 32'(RVALID), 1);
    chk("rdata", RDATA, exp);
    chk("rresp", 32'(RRESP), (addr / 4 < N) ? 0 : 2);
    chk("ar_ready_busy", 32'(ARREADY), 0);
    RREADY = 1;
    tick;
    RREADY = 0;
    chk("rvalid_clear", 32'(RVALID), 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) m[i] = RV;
    // Reset state
    repeat (2) tick;
    chk("rst_awready", 32'(AWREADY), 1);
    chk("rst_bvalid", 32'(BVALID), 0);
    rst = 0;
    tick;
    chk("idle_awready", 32'(AWREADY), 1);
    chk("idle_wready", 32'(WREADY), 1);
    chk("idle_arready", 32'(ARREADY), 1);
    chk("idle_bvalid", 32'(BVALID), 0);
    chk("idle_rvalid", 32'(RVALID), 0);
    chk("idle_bresp", 32'(BRESP), 0);
    chk("idle_rresp", 32'(RRESP), 0);
    chk("idle_rdata", RDATA, 0);
    chk_regs("reset");

    // Same-cycle AW and W, then readback
    axi_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0);
    chk("reg1_deadbeef", regs_o[63:32], 32'hDEADBEEF);
    axi_read(32'h04);

    // W three cycles ahead of AW with partial strobes
    axi_write(32'h08, 32'hAABBCCDD, 4'hF, 0, 0);
    axi_write(32'h08, 32'h11223344, 4'h5, 3, 0);
    chk("reg2_merge", regs_o[95:64], 32'hAA22CC44);
    axi_write(32'h10, 32'h0BADF00D, 4'hA, 2, 1);

    // Out of range write and read
    axi_write(32'h20, 32'hFFFFFFFF, 4'hF, 0, 0);
    chk_regs("oor_write");
    axi_read(32'h20);

    // Zero strobe in range
    axi_write(32'h18, 32'hFFFFFFFF, 4'h0, 0, 0);
    chk_regs("zero_strb");

    // Response back-pressure with a concurrent read
    AWADDR = 32'h14; WDATA = 32'h12345678; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
    tick;
    AWVALID = 0; WVALID = 0;
    void'(model_write(32'h14, 32'h12345678, 4'hF));
    for (int k = 0; k < 5; k++) begin
      chk("bp_bvalid", 32'(BVALID), 1);
      chk("bp_bresp", 32'(BRESP), 0);
      chk("bp_awready", 32'(AWREADY), 0);
      chk("bp_wready", 32'(WREADY), 0);
      if (k == 0) begin ARADDR = 32'h04; ARVALID = 1; end
      if (k == 1) begin
        ARVALID = 0;
        chk("bp_rvalid", 32'(RVALID), 1);
        chk("bp_rdata", RDATA, m[1]);
        RREADY = 1;
      end
      if (k == 2) begin
        RREADY = 0;
        chk("bp_rvalid_clear", 32'(RVALID), 0);
      end
      tick;
    end
    BREADY = 1;
    tick;
    BREADY = 0;
    chk("bp_bvalid_clear", 32'(BVALID), 0);
    chk("bp_reg5", regs_o[191:160], 32'h12345678);

    // Read and write of the same register committing on one edge
    axi_write(32'h0C, 32'h1, 4'hF, 0, 0);
    AWADDR = 32'h0C; WDATA = 32'h55; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
    ARADDR = 32'h0C; ARVALID = 1;
    tick;
    AWVALID = 0; WVALID = 0; ARVALID = 0;
    chk("rw_rdata_old", RDATA, 32'h1);
    chk("rw_bvalid", 32'(BVALID), 1);
    void'(model_write(32'h0C, 32'h55, 4'hF));
    BREADY = 1; RREADY = 1;
    tick;
    BREADY = 0; RREADY = 0;
    axi_read(32'h0C);

    // Random traffic
    for (int it = 0; it < 40; it++) begin
      logic [31:0] a, d;
      a = 32'($urandom_range(0, N + 1)) * 4 + 32'($urandom_range(0, 3));
      d = $urandom;
      axi_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      axi_read(32'($urandom_range(0, N + 1)) * 4 + 32'($urandom_range(0, 3)));
    end
    chk_regs("random");

    // Reset with a held AW and a pending read response
    AWADDR = 32'h04; AWVALID = 1; ARADDR = 32'h00; ARVALID = 1;
    tick;
    AWVALID = 0; ARVALID = 0;
    chk("pre_rst_rvalid", 32'(RVALID), 1);
    chk("pre_rst_awready", 32'(AWREADY), 0);
    #2 rst = 1;
    #1;
    chk("async_rvalid", 32'(RVALID), 0);
    chk("async_awready", 32'(AWREADY), 1);
    chk("async_wready", 32'(WREADY), 1);
    chk("async_arready", 32'(ARREADY), 1);
    tick;
    rst = 0;
    tick;
    for (int i = 0; i < N; i++) m[i] = RV;
    chk_regs("post_rst");
    WDATA = 32'hFFFFFFFF; WSTRB = 4'hF; WVALID = 1;
    tick;
    WVALID = 0;
    chk("stale_bvalid", 32'(BVALID), 0);
    chk("stale_wready", 32'(WREADY), 0);
    chk("stale_awready", 32'(AWREADY), 1);
    tick;
    chk("stale_bvalid2", 32'(BVALID), 0);
    chk("stale_reg1", regs_o[63:32], RV);
    AWADDR = 32'h18; AWVALID = 1;
    tick;
    AWVALID = 0;
    chk("late_aw_bvalid", 32'(BVALID), 1);
    void'(model_write(32'h18, 32'hFFFFFFFF, 4'hF));
    BREADY = 1;
    tick;
    BREADY = 0;
    chk_regs("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/axi4_lite_reg_slave.md
AXI4_LITE_REG_SLAVE -- requirements
Module: axi4_lite_reg_slave

Interface
REQ-001 SHALL have parameters: NUM_REGS, default 8, number of 32-bit registers (power of 2, 2..256); RESET_VAL, default 32'h0, reset value of every register.
REQ-002 SHALL have ports (name direction width meaning):
- clk  in  1  sole clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- AWADDR in 32, AWVALID in 1, AWREADY out 1: write-address channel
- WDATA in 32, WSTRB in 4, WVALID in 1, WREADY out 1: write-data channel
- BRESP out 2, BVALID out 1, BREADY in 1: write-response channel
- ARADDR in 32, ARVALID in 1, ARREADY out 1: read-address channel
- RDATA out 32, RRESP out 2, RVALID out 1, RREADY in 1: read-data channel
- regs_o out NUM_REGS*32: live register contents, register i at bits [32*i+31:32*i]
REQ-003 SHALL use one clock; reset asynchronous, active-high, as stated above.

Function
REQ-004 Decode SHALL be: index = ADDR[log2(NUM_REGS)+1:2]; ADDR[1:0] ignored; in range iff ADDR[31:2] < NUM_REGS.
REQ-005 A channel handshake SHALL occur on a rising edge where VALID and READY are both 1.
REQ-006 Write path SHALL hold two independent flags, aw_held and w_held, plus captured AWADDR/WDATA/WSTRB; AW and W SHALL be accepted in either order or in the same cycle.
REQ-007 AWREADY SHALL equal !aw_held && !BVALID; WREADY SHALL equal !w_held && !BVALID (combinational from registered state).
REQ-008 On the edge where the second of AW/W is accepted (or both together), the write SHALL commit: each byte lane b with strobe bit b = 1 updates bits [8b+7:8b] of the addressed register; lanes with strobe bit 0 are unchanged; both held flags clear.
REQ-009 On that same edge, BVALID SHALL go to 1 with BRESP = 2'b00 (in range) or 2'b10 SLVERR (out of range, no register modified); write latency from last handshake to BVALID = 1 cycle.
REQ-010 BVALID and BRESP SHALL stay stable until the edge where BREADY = 1, then BVALID clears; a new AW/W SHALL be accepted no earlier than the following cycle.
REQ-011 WSTRB = 4'b0000 in range SHALL complete with OKAY and modify nothing.
REQ-012 ARREADY SHALL equal !RVALID.
REQ-013 On an AR handshake, RVALID SHALL go to 1 on that edge with RDATA = addressed register value before any write committed on the same edge, RRESP = 2'b00; out of range: RDATA = 32'h0, RRESP = 2'b10.
REQ-014 RVALID/RDATA/RRESP SHALL stay stable until the edge where RREADY = 1, then RVALID clears; back-to-back reads therefore sustain one read per 2 cycles.
REQ-015 Read and write paths SHALL be independent; simultaneous read and write commit to the same register SHALL return the old value (REQ-013) and store the new value.
REQ-016 regs_o SHALL reflect register contents from the cycle after commit.

Reset
REQ-017 While rst = 1 and after release: all registers = RESET_VAL; aw_held = w_held = 0; BVALID = RVALID = 0; BRESP = RRESP = 2'b00; RDATA = 32'h0; therefore AWREADY = WREADY = ARREADY = 1.
REQ-018 Reset asserted mid-transaction SHALL discard held AW/W and pending B/R responses with no register update; first edge after release is a normal idle cycle.

Verification
REQ-019 AW(0x04) and W(0xDEADBEEF, WSTRB 0xF) in same cycle, BREADY = 1 -> BVALID next cycle, BRESP 00; read 0x04 -> RDATA 0xDEADBEEF, RRESP 00.
REQ-020 W(0x11223344, WSTRB 0x5) 3 cycles before AW(0x08), register 2 = 0xAABBCCDD -> AWREADY stays 1, WREADY 0 while waiting; register 2 becomes 0xAA22CC44.
REQ-021 AW(0x20) with NUM_REGS = 8 -> BRESP 10, regs_o unchanged; read 0x20 -> RDATA 0, RRESP 10.
REQ-022 BREADY held 0 for 5 cycles after BVALID -> BVALID/BRESP stable, AWREADY = WREADY = 0 throughout; read concurrently completes normally.
REQ-023 Read and write to 0x0C committing same edge, old value 0x1 -> RDATA 0x1; subsequent read returns new value.
REQ-024 rst pulsed while aw_held = 1 and RVALID = 1 -> RVALID 0, all readies 1, registers = RESET_VAL, no stale write on later W.
